// File: rtl/reorder_buffer.sv
// reorder_buffer: in-order retirement buffer with multi-lane dispatch, CDB capture, branch flush and sticky halt.
// Optional ROB_BYPASS_EN forwards same-cycle CDB results onto entry_ready/entry_value (commit stays registered).
module reorder_buffer #(
    parameter int DEPTH      = 16,
    parameter int IDX_W      = 4,
    parameter int DATA_W     = 16,
    parameter int REG_W      = 4,
    parameter int DISPATCH_W = 4,
    parameter int CDB_W      = 4,
    parameter int COMMIT_W   = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [DISPATCH_W-1:0]       dispatch_valid,
    input  logic [DISPATCH_W*REG_W-1:0] dispatch_rt,
    input  logic [DISPATCH_W-1:0]       dispatch_halt,
    output logic                        dispatch_ack,
    output logic [DISPATCH_W*IDX_W-1:0] dispatch_idx,
    output logic [IDX_W:0]              free_count,
    input  logic [CDB_W-1:0]            cdb_valid,
    input  logic [CDB_W*IDX_W-1:0]      cdb_idx,
    input  logic [CDB_W*DATA_W-1:0]     cdb_value,
    output logic [DEPTH-1:0]            entry_ready,
    output logic [DEPTH*DATA_W-1:0]     entry_value,
    input  logic                        flush_valid,
    input  logic [IDX_W-1:0]            flush_idx,
    output logic [COMMIT_W-1:0]         commit_valid,
    output logic [COMMIT_W*REG_W-1:0]   commit_rt,
    output logic [COMMIT_W*DATA_W-1:0]  commit_value,
    output logic [COMMIT_W*IDX_W-1:0]   commit_idx,
    output logic [IDX_W-1:0]            head,
    output logic [IDX_W:0]              count,
    output logic                        halted
);
    localparam logic [IDX_W:0] DEPTH_C = (IDX_W+1)'(DEPTH);

    logic [DEPTH-1:0]  r_valid;
    logic [DEPTH-1:0]  r_ready;
    logic [DEPTH-1:0]  r_halt;
    logic [REG_W-1:0]  r_rt    [DEPTH];
    logic [DATA_W-1:0] r_value [DEPTH];
    logic [IDX_W-1:0]  r_head;
    logic [IDX_W-1:0]  r_tail;
    logic [IDX_W:0]    r_count;
    logic              r_halted;

    logic [IDX_W:0]    w_n;
    logic [IDX_W:0]    w_free;
    logic [IDX_W-1:0]  w_didx    [DISPATCH_W];
    logic [IDX_W-1:0]  w_cdb_idx [CDB_W];
    logic [IDX_W-1:0]  w_cidx    [COMMIT_W];
    logic [IDX_W-1:0]  w_age     [DEPTH];
    logic [IDX_W-1:0]  w_flush_age;
    logic              w_flush_apply;
    logic [DEPTH-1:0]  w_squash;
    logic [DEPTH-1:0]  w_retire;
    logic [IDX_W:0]    w_retire_n;
    logic              w_halt_retire;
    logic              w_stop;
    logic [IDX_W:0]    w_count_next;
    logic [IDX_W-1:0]  w_tail_next;

    assign head       = r_head;
    assign count      = r_count;
    assign halted     = r_halted;
    assign w_free     = DEPTH_C - r_count;
    assign free_count = w_free;

    // Dispatch: all-or-nothing allocation at tail, blocked by flush and halt.
    always_comb begin
        // NOTE: every combinational output gets a default before any conditional write, so no latch is inferred.
        w_n = '0;
        for (int i = 0; i < DISPATCH_W; i++) begin
            w_n = w_n + {{IDX_W{1'b0}}, dispatch_valid[i]};
        end
        for (int i = 0; i < DISPATCH_W; i++) begin
            w_didx[i] = r_tail + IDX_W'(i);
            dispatch_idx[i*IDX_W +: IDX_W] = w_didx[i];
        end
        dispatch_ack = (w_n != '0) && (w_n <= w_free) && !flush_valid && !r_halted;
    end

    always_comb begin
        for (int c = 0; c < CDB_W; c++) begin
            w_cdb_idx[c] = cdb_idx[c*IDX_W +: IDX_W];
        end
    end

    // Flush: ages are measured from head so wrap-around compares correctly.
    always_comb begin
        w_flush_apply = flush_valid && r_valid[flush_idx];
        w_flush_age   = flush_idx - r_head;
        for (int i = 0; i < DEPTH; i++) begin
            w_age[i]    = IDX_W'(i) - r_head;
            w_squash[i] = w_flush_apply && r_valid[i] && (w_age[i] > w_flush_age);
        end
    end

    // Commit scan from head; squashed entries beyond a same-cycle flush point never retire.
    always_comb begin
        commit_valid  = '0;
        commit_rt     = '0;
        commit_value  = '0;
        commit_idx    = '0;
        w_retire      = '0;
        w_retire_n    = '0;
        w_halt_retire = 1'b0;
        w_stop        = r_halted;
        for (int j = 0; j < COMMIT_W; j++) begin
            w_cidx[j] = r_head + IDX_W'(j);
            commit_idx[j*IDX_W +: IDX_W]     = w_cidx[j];
            commit_rt[j*REG_W +: REG_W]      = r_rt[w_cidx[j]];
            commit_value[j*DATA_W +: DATA_W] = r_value[w_cidx[j]];
            if (w_stop || !r_valid[w_cidx[j]] || !r_ready[w_cidx[j]] ||
                (w_flush_apply && (IDX_W'(j) > w_flush_age))) begin
                w_stop = 1'b1;
            end else begin
                w_retire[w_cidx[j]] = 1'b1;
                w_retire_n          = w_retire_n + 1'b1;
                if (r_halt[w_cidx[j]]) begin
                    w_halt_retire = 1'b1;
                    w_stop        = 1'b1;
                end else begin
                    commit_valid[j] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        if (w_flush_apply) begin
            w_count_next = {1'b0, w_flush_age} + (IDX_W+1)'(1) - w_retire_n;
            w_tail_next  = flush_idx + IDX_W'(1);
        end else if (dispatch_ack) begin
            w_count_next = r_count + w_n - w_retire_n;
            w_tail_next  = r_tail + w_n[IDX_W-1:0];
        end else begin
            w_count_next = r_count - w_retire_n;
            w_tail_next  = r_tail;
        end
    end

    always_comb begin
        entry_ready = r_valid & r_ready;
        for (int i = 0; i < DEPTH; i++) begin
            entry_value[i*DATA_W +: DATA_W] = r_value[i];
        end
`ifdef ROB_BYPASS_EN
        for (int c = 0; c < CDB_W; c++) begin
            if (cdb_valid[c] && r_valid[w_cdb_idx[c]]) begin
                entry_ready[w_cdb_idx[c]] = 1'b1;
                entry_value[w_cdb_idx[c]*DATA_W +: DATA_W] = cdb_value[c*DATA_W +: DATA_W];
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid  <= '0;
            r_ready  <= '0;
            r_halt   <= '0;
            r_head   <= '0;
            r_tail   <= '0;
            r_count  <= '0;
            r_halted <= 1'b0;
            // NOTE: the entry array is reset too, because entry_value must read zero straight out of reset.
            for (int i = 0; i < DEPTH; i++) begin
                r_rt[i]    <= '0;
                r_value[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking writes; a later write in this block overrides an earlier one, which gives the
            // highest CDB channel priority and lets invalidation win over a capture on the same entry.
            for (int c = 0; c < CDB_W; c++) begin
                if (cdb_valid[c] && r_valid[w_cdb_idx[c]]) begin
                    r_ready[w_cdb_idx[c]] <= 1'b1;
                    r_value[w_cdb_idx[c]] <= cdb_value[c*DATA_W +: DATA_W];
                end
            end
            for (int i = 0; i < DEPTH; i++) begin
                if (w_retire[i] || w_squash[i]) begin
                    r_valid[i] <= 1'b0;
                    r_ready[i] <= 1'b0;
                end
            end
            if (dispatch_ack) begin
                for (int l = 0; l < DISPATCH_W; l++) begin
                    if (dispatch_valid[l]) begin
                        r_valid[w_didx[l]] <= 1'b1;
                        r_ready[w_didx[l]] <= dispatch_halt[l];
                        r_halt[w_didx[l]]  <= dispatch_halt[l];
                        r_rt[w_didx[l]]    <= dispatch_rt[l*REG_W +: REG_W];
                        r_value[w_didx[l]] <= '0;
                    end
                end
            end
            r_head  <= r_head + w_retire_n[IDX_W-1:0];
            r_tail  <= w_tail_next;
            r_count <= w_count_next;
            if (w_halt_retire) begin
                r_halted <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: directed scenarios plus randomized traffic against a queue-based model.
module tb_reorder_buffer;
    localparam int DEPTH  = 16;
    localparam int IDX_W  = 4;
    localparam int DATA_W = 16;
    localparam int REG_W  = 4;
    localparam int DW     = 4;
    localparam int CW     = 4;
    localparam int MW     = 4;
`ifdef ROB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic [DW-1:0]           dispatch_valid;
    logic [DW*REG_W-1:0]     dispatch_rt;
    logic [DW-1:0]           dispatch_halt;
    logic                    dispatch_ack;
    logic [DW*IDX_W-1:0]     dispatch_idx;
    logic [IDX_W:0]          free_count;
    logic [CW-1:0]           cdb_valid;
    logic [CW*IDX_W-1:0]     cdb_idx;
    logic [CW*DATA_W-1:0]    cdb_value;
    logic [DEPTH-1:0]        entry_ready;
    logic [DEPTH*DATA_W-1:0] entry_value;
    logic                    flush_valid;
    logic [IDX_W-1:0]        flush_idx;
    logic [MW-1:0]           commit_valid;
    logic [MW*REG_W-1:0]     commit_rt;
    logic [MW*DATA_W-1:0]    commit_value;
    logic [MW*IDX_W-1:0]     commit_idx;
    logic [IDX_W-1:0]        head;
    logic [IDX_W:0]          count;
    logic                    halted;

    reorder_buffer #(
        .DEPTH(DEPTH), .IDX_W(IDX_W), .DATA_W(DATA_W), .REG_W(REG_W),
        .DISPATCH_W(DW), .CDB_W(CW), .COMMIT_W(MW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .dispatch_valid(dispatch_valid), .dispatch_rt(dispatch_rt), .dispatch_halt(dispatch_halt),
        .dispatch_ack(dispatch_ack), .dispatch_idx(dispatch_idx), .free_count(free_count),
        .cdb_valid(cdb_valid), .cdb_idx(cdb_idx), .cdb_value(cdb_value),
        .entry_ready(entry_ready), .entry_value(entry_value),
        .flush_valid(flush_valid), .flush_idx(flush_idx),
        .commit_valid(commit_valid), .commit_rt(commit_rt), .commit_value(commit_value),
        .commit_idx(commit_idx), .head(head), .count(count), .halted(halted)
    );

    always #5 clk = ~clk;

    // Model: program-ordered queue of live entries, oldest first.
    typedef struct {
        int                idx;
        logic [REG_W-1:0]  rt;
        bit                halt;
        bit                ready;
        logic [DATA_W-1:0] value;
    } ent_t;

    ent_t rob[$];
    int   m_head;
    bit   m_halted;
    int   total;
    int   bad;

    int   e_retire;
    int   e_flush_pos;
    int   e_tail;
    int   e_n;
    bit   e_ack;
    bit   e_halt_ret;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        dispatch_valid = '0;
        dispatch_rt    = '0;
        dispatch_halt  = '0;
        cdb_valid      = '0;
        cdb_idx        = '0;
        cdb_value      = '0;
        flush_valid    = 1'b0;
        flush_idx      = '0;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 1'b0;
        rob.delete();
        m_head   = 0;
        m_halted = 1'b0;
        #1;
        check("rst_count", count, 0);
        check("rst_head", head, 0);
        check("rst_free", free_count, DEPTH);
        check("rst_halted", halted, 0);
        check("rst_ack", dispatch_ack, 0);
        check("rst_commit_valid", commit_valid, 0);
        check("rst_entry_ready", entry_ready, 0);
        check("rst_entry_value", entry_value, 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Derive expected outputs for the inputs now applied, then compare.
    task automatic check_cycle();
        logic [MW-1:0]    ecv;
        logic [DEPTH-1:0] erdy;
        logic [DATA_W-1:0] evals [DEPTH];
        #1;
        e_n    = $countones(dispatch_valid);
        e_tail = (m_head + rob.size()) % DEPTH;
        e_ack  = (e_n > 0) && (e_n <= DEPTH - rob.size()) && !flush_valid && !m_halted;
        e_flush_pos = -1;
        if (flush_valid)
            foreach (rob[k]) if (rob[k].idx == int'(flush_idx)) e_flush_pos = k;
        e_retire   = 0;
        e_halt_ret = 1'b0;
        ecv        = '0;
        if (!m_halted) begin
            for (int j = 0; j < MW && j < rob.size(); j++) begin
                if (e_flush_pos >= 0 && j > e_flush_pos) break;
                if (!rob[j].ready) break;
                e_retire++;
                if (rob[j].halt) begin
                    e_halt_ret = 1'b1;
                    break;
                end
                ecv[j] = 1'b1;
            end
        end
        check("ack", dispatch_ack, e_ack);
        for (int i = 0; i < DW; i++)
            check("dispatch_idx", dispatch_idx[i*IDX_W +: IDX_W], (e_tail + i) % DEPTH);
        check("free_count", free_count, DEPTH - rob.size());
        check("count", count, rob.size());
        check("head", head, m_head);
        check("halted", halted, m_halted);
        check("commit_valid", commit_valid, ecv);
        for (int j = 0; j < MW; j++) begin
            if (ecv[j]) begin
                check("commit_rt", commit_rt[j*REG_W +: REG_W], rob[j].rt);
                check("commit_value", commit_value[j*DATA_W +: DATA_W], rob[j].value);
                check("commit_idx", commit_idx[j*IDX_W +: IDX_W], rob[j].idx);
            end
        end
        erdy = '0;
        foreach (rob[k]) begin
            erdy[rob[k].idx]  = rob[k].ready;
            evals[rob[k].idx] = rob[k].value;
        end
        if (BYP) begin
            for (int c = 0; c < CW; c++)
                if (cdb_valid[c])
                    foreach (rob[k])
                        if (rob[k].idx == int'(cdb_idx[c*IDX_W +: IDX_W])) begin
                            erdy[rob[k].idx]  = 1'b1;
                            evals[rob[k].idx] = cdb_value[c*DATA_W +: DATA_W];
                        end
        end
        check("entry_ready", entry_ready, erdy);
        foreach (rob[k])
            check("entry_value", entry_value[rob[k].idx*DATA_W +: DATA_W], evals[rob[k].idx]);
    endtask

    // Advance the model across one rising edge.
    task automatic tick();
        ent_t e;
        @(posedge clk);
        for (int c = 0; c < CW; c++)
            if (cdb_valid[c])
                foreach (rob[k])
                    if (rob[k].idx == int'(cdb_idx[c*IDX_W +: IDX_W])) begin
                        rob[k].ready = 1'b1;
                        rob[k].value = cdb_value[c*DATA_W +: DATA_W];
                    end
        for (int r = 0; r < e_retire; r++) void'(rob.pop_front());
        m_head = (m_head + e_retire) % DEPTH;
        if (e_halt_ret) m_halted = 1'b1;
        if (e_flush_pos >= 0)
            while (rob.size() > e_flush_pos + 1 - e_retire) void'(rob.pop_back());
        if (e_ack) begin
            for (int i = 0; i < e_n; i++) begin
                e.idx   = (e_tail + i) % DEPTH;
                e.rt    = dispatch_rt[i*REG_W +: REG_W];
                e.halt  = dispatch_halt[i];
                e.ready = dispatch_halt[i];
                e.value = '0;
                rob.push_back(e);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        do_reset();

        // Four-lane dispatch after reset.
        dispatch_valid = 4'hF;
        dispatch_rt    = 16'h4321;
        check_cycle();
        check("t1_ack", dispatch_ack, 1);
        check("t1_idx", dispatch_idx, 16'h3210);
        tick();
        idle();
        check_cycle();
        check("t1_count", count, 4);
        check("t1_free", free_count, 12);

        // Out-of-order result must not retire ahead of the older entry.
        cdb_valid = 4'b1000;
        cdb_idx   = 16'h1000;
        cdb_value = {16'h00AA, 48'h0};
        check_cycle();
        check("t2_bypass_rdy", entry_ready[1], BYP);
        tick();
        cdb_idx   = 16'h0000;
        cdb_value = {16'h0055, 48'h0};
        check_cycle();
        check("t2_rdy1_registered", entry_ready[1], 1);
        check("t2_no_early_commit", commit_valid, 0);
        tick();
        idle();
        check_cycle();
        check("t2_commit_valid", commit_valid, 4'b0011);
        check("t2_commit_rt", commit_rt[7:0], 8'h21);
        check("t2_commit_value", commit_value[31:0], 32'h00AA_0055);
        tick();
        check_cycle();
        check("t2_head", head, 2);

        // Capacity: 14 occupied rejects 3, accepts 2, tail wraps to 0.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            dispatch_valid = (k == 3) ? 4'b0011 : 4'b1111;
            dispatch_rt    = 16'($urandom());
            check_cycle();
            tick();
        end
        dispatch_valid = 4'b0111;
        check_cycle();
        check("t3_reject", dispatch_ack, 0);
        tick();
        check_cycle();
        check("t3_count14", count, 14);
        dispatch_valid = 4'b0011;
        check_cycle();
        check("t3_accept", dispatch_ack, 1);
        tick();
        dispatch_valid = 4'b0001;
        check_cycle();
        check("t3_count16", count, 16);
        check("t3_tail_wrap", dispatch_idx[3:0], 0);
        check("t3_full_reject", dispatch_ack, 0);
        cdb_valid = 4'b0001;
        cdb_value = 64'h0000_0000_0000_0777;
        tick();
        cdb_valid = '0;
        check_cycle();
        check("t3_commit_lane0", commit_valid, 4'b0001);
        check("t3_full_during_commit", dispatch_ack, 0);
        tick();
        check_cycle();
        check("t3_ack_after_commit", dispatch_ack, 1);
        tick();

        // Flush keeps the branch entry and squashes younger ones.
        do_reset();
        dispatch_valid = 4'hF;
        dispatch_rt    = 16'h5678;
        check_cycle();
        tick();
        dispatch_valid = 4'b0011;
        check_cycle();
        tick();
        idle();
        flush_valid = 1'b1;
        flush_idx   = 4'd2;
        check_cycle();
        tick();
        idle();
        cdb_valid = 4'b0001;
        cdb_idx   = 16'h0004;
        cdb_value = 64'h0000_0000_0000_1234;
        check_cycle();
        check("t4_count", count, 3);
        check("t4_tail", dispatch_idx[3:0], 3);
        tick();
        idle();
        check_cycle();
        check("t4_ignored_write", entry_ready, 0);

        // Halt behind two ready entries; colliding channels, highest wins.
        do_reset();
        dispatch_valid = 4'b0111;
        dispatch_rt    = 16'h0321;
        dispatch_halt  = 4'b0100;
        check_cycle();
        tick();
        idle();
        cdb_valid = 4'b0111;
        cdb_idx   = 16'h0010;
        cdb_value = {16'h0000, 16'h0099, 16'h0022, 16'h0011};
        check_cycle();
        tick();
        idle();
        check_cycle();
        check("t5_commit_valid", commit_valid, 4'b0011);
        check("t5_collision", commit_value[31:0], 32'h0022_0099);
        tick();
        check_cycle();
        check("t5_halted", halted, 1);
        check("t5_count", count, 0);
        check("t5_head", head, 3);
        for (int k = 0; k < 3; k++) begin
            dispatch_valid = 4'b0001;
            check_cycle();
            check("t5_no_ack", dispatch_ack, 0);
            tick();
        end

        // Randomized traffic, no halts.
        do_reset();
        for (int cyc = 0; cyc < 400; cyc++) begin
            int n;
            int sel;
            n = $urandom_range(0, DW);
            dispatch_valid = DW'((1 << n) - 1);
            dispatch_rt    = 16'($urandom());
            dispatch_halt  = '0;
            cdb_valid      = CW'($urandom());
            for (int c = 0; c < CW; c++) begin
                if (rob.size() > 0 && $urandom_range(0, 3) != 0)
                    sel = rob[$urandom_range(0, rob.size() - 1)].idx;
                else
                    sel = $urandom_range(0, DEPTH - 1);
                cdb_idx[c*IDX_W +: IDX_W]    = IDX_W'(sel);
                cdb_value[c*DATA_W +: DATA_W] = DATA_W'($urandom());
            end
            flush_valid = ($urandom_range(0, 15) == 0);
            if (rob.size() > 0 && $urandom_range(0, 3) != 0)
                sel = rob[$urandom_range(0, rob.size() - 1)].idx;
            else
                sel = $urandom_range(0, DEPTH - 1);
            flush_idx = IDX_W'(sel);
            check_cycle();
            tick();
        end

        // Asynchronous reset between clock edges with a populated buffer.
        dispatch_valid = 4'hF;
        #2;
        do_reset();
        check_cycle();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reorder_buffer.md
# reorder_buffer

Parametrised in-order retirement buffer for the out-of-order core, successor to the fixed 16-entry/4-lane ROB. Allocates entries for up to DISPATCH_W instructions per cycle from the instruction buffer. Captures results from CDB_W common-data-bus channels and forwards per-entry ready/value to dispatch. Retires up to COMMIT_W entries per cycle in program order to the register file. Adds branch-mispredict flush and sticky halt, which the fixed ROB lacks.

## Interface
- DEPTH, 16, entries; power of two, 4..64
- IDX_W, 4, log2(DEPTH)
- DATA_W, 16, result width
- REG_W, 4, architectural register index width
- DISPATCH_W, 4, allocation lanes
- CDB_W, 4, result-bus channels
- COMMIT_W, 4, retirement lanes; ≤ DEPTH

- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- dispatch_valid  in  DISPATCH_W  lane i requests allocation; set bits contiguous from bit 0, lane 0 oldest
- dispatch_rt  in  DISPATCH_W*REG_W  destination register per lane
- dispatch_halt  in  DISPATCH_W  lane carries a halt
- dispatch_ack  out  1  request accepted this cycle
- dispatch_idx  out  DISPATCH_W*IDX_W  index assigned to lane i: (tail+i) mod DEPTH
- free_count  out  IDX_W+1  DEPTH − count
- cdb_valid  in  CDB_W  channel carries a result
- cdb_idx  in  CDB_W*IDX_W  target entry
- cdb_value  in  CDB_W*DATA_W  result
- entry_ready  out  DEPTH  entry valid with result captured
- entry_value  out  DEPTH*DATA_W  captured result per entry
- flush_valid  in  1  mispredict; squash entries younger than flush_idx
- flush_idx  in  IDX_W  mispredicted branch entry (kept)
- commit_valid  out  COMMIT_W  lane j writes the register file
- commit_rt  out  COMMIT_W*REG_W  destination
- commit_value  out  COMMIT_W*DATA_W  value
- commit_idx  out  COMMIT_W*IDX_W  retiring entry index, used as writer tag
- head  out  IDX_W  oldest entry
- count  out  IDX_W+1  occupied entries
- halted  out  1  sticky; halt retired

## Operation
- State: per-entry valid, ready, halt, rt, value; head, tail, count registers. count disambiguates full and empty.
- Dispatch: n = popcount(dispatch_valid). dispatch_ack = n>0 && n ≤ free_count && !flush_valid && !halted. Acceptance is all-or-nothing. On ack: entries tail..tail+n−1 valid, ready = halt bit, value 0. tail += n mod DEPTH.
- CDB capture: for each channel with cdb_valid, if entry cdb_idx is valid, set ready and store value. Writes to invalid entries are ignored. If channels collide on one index, the highest channel number wins.
- Commit: scan from head across COMMIT_W entries; stop at the first entry that is invalid or not ready. Retire every entry scanned before the stop.
  - A non-halt entry drives commit_valid=1 with its rt and value.
  - A halt entry retires with commit_valid=0, sets halted, and ends the scan.
  - Retired entries are invalidated; head and count advance by the number retired.
- Halted: no commits and no dispatch acks until reset. CDB capture continues.
- Flush: if flush_valid and entry flush_idx is valid, invalidate every entry strictly younger than flush_idx. tail := flush_idx+1 and count is recomputed. If flush_idx is not valid, the flush is ignored.
- Flush and commit in the same cycle: both apply. The branch entry is not squashed and may retire that cycle.
- Reset: all entries invalid. head=tail=0, count=0, free_count=DEPTH. halted=0, dispatch_ack=0, commit_valid=0, entry_ready=0, entry_value=0.

## Timing
- dispatch_idx, dispatch_ack and free_count are combinational from registered state and inputs; allocation takes effect at the edge.
- CDB capture at edge N makes entry_ready visible after edge N. Commit outputs are combinational in cycle N+1, and retirement occurs at edge N+1.
- Commit lanes reflect state before this cycle's CDB writes. A result arriving in cycle N cannot retire in cycle N.
- Freed slots are reflected in free_count the cycle after retirement. A full ROB accepts no dispatch until one edge after a commit.
- Wrap-around: all index arithmetic is mod DEPTH.
- rst_n assertion mid-operation clears state immediately, independent of clk.

## Configuration
- ROB_BYPASS_EN defined:
  - entry_ready and entry_value also reflect same-cycle cdb_valid/cdb_value combinationally, so dispatch sees results one cycle earlier.
  - Commit still uses registered state only.
- ROB_BYPASS_EN undefined: entry_ready and entry_value are registered only.

## Test plan
- Reset, then dispatch 4 lanes rt=1,2,3,4 → dispatch_ack=1, dispatch_idx=0,1,2,3; next cycle count=4, free_count=12.
- CDB ch3 writes idx1=0x00AA, then idx0=0x0055 a cycle later → idx1 does not retire first; the cycle after the idx0 write, commit_valid=0b0011 with rt 1,2 and values 0x0055, 0x00AA; head=2.
- Fill to 14 entries, dispatch 3 → dispatch_ack=0, state unchanged. Dispatch 2 → ack, count=16, tail wraps to 0.
- Entries 0..5 valid, flush_idx=2 → entries 3..5 invalid, tail=3, count=3. A later CDB write to idx4 is ignored.
- Halt at idx2 behind two ready entries → entries 0,1 commit, halt retires with commit_valid lane2=0, halted=1. Further dispatch is never acked.
- Same cycle: CDB write to idx0 with dispatch_idx entry empty (ROB_BYPASS_EN) → entry_ready[0]=1 that cycle. Without the macro → entry_ready[0]=1 one cycle later.
